alu_entry_ctrl: RTL and testbench

Parametrised operand-entry and result-presentation controller for the mALUma board top. It loads two DATA_W-bit operands from the 16 slide switches one 16-bit chunk at a time, captures opcode and FP mode, and issues a one-cycle start to the ALU. It then captures the result, watches for a compute timeout, and drives the 7-segment character codes and LEDs. Compared with the fixed 32-bit sequencer, it adds variable operand width, a back-step button, re-run from the result screen, a timeout/error state and result paging.

---
 rtl/alu_entry_ctrl.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_alu_entry_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_entry_ctrl.sv
// alu_entry_ctrl
// Operand-entry and result-presentation controller for the board top.
// Two DATA_W-bit operands are entered from the switch bank one 16-bit chunk
// at a time, most-significant chunk first. Opcode and FP mode are captured
// next, and a one-cycle start is issued to the ALU. The controller then
// captures the result (or times out) and drives 7-segment character codes
// and LEDs. Results wider than 16 bits are shown one 16-bit page at a time.
module alu_entry_ctrl #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              next_pulse,
  input  logic              back_pulse,
  input  logic [15:0]       sw,
  output logic [DATA_W-1:0] alu_op_a,
  output logic [DATA_W-1:0] alu_op_b,
  output logic [2:0]        alu_op_code,
  output logic              alu_mode_fp,
  output logic              alu_start,
  input  logic              alu_valid_out,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [4:0]        alu_flags,
  output logic              show_result,
  output logic              error,
  output logic [15:0]       led,
  output logic [4:0]        disp_d3,
  output logic [4:0]        disp_d2,
  output logic [4:0]        disp_d1,
  output logic [4:0]        disp_d0
);

  localparam int CHUNKS = DATA_W / 16;
  localparam logic [1:0] IDX_LAST = 2'(CHUNKS - 1);

  // cnt holds the number of COMPUTE cycles already completed without a
  // valid, so the last tolerated cycle is the one where cnt == TIMEOUT_CYC-1.
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

  // Display driver character codes beyond the plain hex digits.
  localparam logic [4:0] CH_N     = 5'h10;
  localparam logic [4:0] CH_R     = 5'h11;
  localparam logic [4:0] CH_L     = 5'h12;
  localparam logic [4:0] CH_BLANK = 5'h14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_CONFIG,
    S_COMPUTE,
    S_DISPLAY,
    S_ERROR
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       idx;
  logic [1:0]       idx_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             start_nxt;
  logic             wr_a;
  logic             wr_b;
  logic             wr_cfg;
  logic             capture;

  logic [DATA_W-1:0] result_q;
  logic [4:0]        flags_q;
  logic [1:0]        page_sel;
  logic [15:0]       page_data;

  // Control registers: FSM state, chunk index, timeout counter, start pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= IDX_LAST;
      cnt       <= '0;
      alu_start <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      alu_start <= start_nxt;
    end
  end

  // Next-state decode. next_pulse is tested first everywhere, so a
  // simultaneous back_pulse is dropped without any extra gating.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    start_nxt = 1'b0;
    wr_a      = 1'b0;
    wr_b      = 1'b0;
    wr_cfg    = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (next_pulse) begin
          state_nxt = S_LOAD_A;
          idx_nxt   = IDX_LAST;
        end
      end
      S_LOAD_A: begin
        if (next_pulse) begin
          wr_a = 1'b1;
          if (idx != 2'd0) begin
            idx_nxt = idx - 2'd1;
          end else begin
            state_nxt = S_LOAD_B;
            idx_nxt   = IDX_LAST;
          end
        end else if (back_pulse) begin
          if (idx != IDX_LAST) begin
            idx_nxt = idx + 2'd1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_LOAD_B: begin
        if (next_pulse) begin
          wr_b = 1'b1;
          if (idx != 2'd0) begin
            idx_nxt = idx - 2'd1;
          end else begin
            state_nxt = S_CONFIG;
          end
        end else if (back_pulse) begin
          if (idx != IDX_LAST) begin
            idx_nxt = idx + 2'd1;
          end else begin
            // Stepping back out of operand B resumes on A's last chunk.
            state_nxt = S_LOAD_A;
            idx_nxt   = 2'd0;
          end
        end
      end
      S_CONFIG: begin
        if (next_pulse) begin
          wr_cfg    = 1'b1;
          start_nxt = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_COMPUTE;
        end else if (back_pulse) begin
          state_nxt = S_LOAD_B;
          idx_nxt   = 2'd0;
        end
      end
      S_COMPUTE: begin
        if (alu_valid_out) begin
          capture   = 1'b1;
          state_nxt = S_DISPLAY;
        end else if (TIMEOUT_CYC != 0) begin
          if (cnt == CNT_LAST) begin
            state_nxt = S_ERROR;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      S_DISPLAY: begin
        if (next_pulse) begin
          state_nxt = S_IDLE;
        end else if (back_pulse) begin
          // Re-run path: operands are kept, only opcode/mode are re-entered.
          state_nxt = S_CONFIG;
        end
      end
      S_ERROR: begin
        if (next_pulse) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand, configuration and result registers, written on decoded strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op_a    <= '0;
      alu_op_b    <= '0;
      alu_op_code <= 3'd0;
      alu_mode_fp <= 1'b0;
      result_q    <= '0;
      flags_q     <= 5'd0;
    end else begin
      for (int c = 0; c < CHUNKS; c++) begin
        if (wr_a && (idx == 2'(c))) begin
          alu_op_a[16*c +: 16] <= sw;
        end
        if (wr_b && (idx == 2'(c))) begin
          alu_op_b[16*c +: 16] <= sw;
        end
      end
      if (wr_cfg) begin
        alu_op_code <= sw[2:0];
        alu_mode_fp <= sw[14];
      end
      if (capture) begin
        result_q <= alu_result;
        flags_q  <= alu_flags;
      end
    end
  end

  // Result page chosen by sw[15:14], wrapped to the number of chunks.
  assign page_sel = 2'({30'd0, sw[15:14]} % CHUNKS);

  // Selects the 16-bit page of the captured result for display and LEDs.
  always_comb begin
    page_data = 16'h0000;
    for (int c = 0; c < CHUNKS; c++) begin
      if (page_sel == 2'(c)) begin
        page_data = result_q[16*c +: 16];
      end
    end
  end

  // Display characters, LEDs and status flags decoded from the current state.
  always_comb begin
    disp_d3     = CH_BLANK;
    disp_d2     = CH_BLANK;
    disp_d1     = CH_BLANK;
    disp_d0     = CH_BLANK;
    led         = 16'h0000;
    show_result = 1'b0;
    error       = 1'b0;
    case (state)
      S_LOAD_A: begin
        disp_d3 = CH_L;
        disp_d2 = 5'h0D;
        disp_d1 = 5'h0A;
        disp_d0 = {3'b000, idx};
      end
      S_LOAD_B: begin
        disp_d3 = CH_L;
        disp_d2 = 5'h0D;
        disp_d1 = 5'h0B;
        disp_d0 = {3'b000, idx};
      end
      S_CONFIG: begin
        disp_d3 = 5'h0C;
        disp_d2 = 5'h00;
        disp_d1 = CH_N;
        disp_d0 = 5'h0F;
      end
      S_ERROR: begin
        error   = 1'b1;
        disp_d3 = 5'h0E;
        disp_d2 = CH_R;
        disp_d1 = CH_R;
        disp_d0 = CH_BLANK;
      end
      S_DISPLAY: begin
        show_result = 1'b1;
        if (sw[13]) begin
          disp_d3 = 5'h0F;
          disp_d2 = CH_L;
          disp_d1 = {4'b0000, flags_q[4]};
          disp_d0 = {1'b0, flags_q[3:0]};
          led     = {11'b0, flags_q};
        end else begin
          disp_d3 = {1'b0, page_data[15:12]};
          disp_d2 = {1'b0, page_data[11:8]};
          disp_d1 = {1'b0, page_data[7:4]};
          disp_d0 = {1'b0, page_data[3:0]};
          led     = page_data;
        end
      end
      default: begin
        disp_d3 = CH_BLANK;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_entry_ctrl.sv
// Bench for alu_entry_ctrl: a 32-bit instance with an 8-cycle timeout and a
// 64-bit instance with the timeout disabled, each tracked by a reference model.
module tb_alu_entry_ctrl;

  localparam int S_ID = 0, S_LA = 1, S_LB = 2, S_CF = 3, S_CP = 4, S_DS = 5, S_ER = 6;

  typedef struct {
    int          st;
    int          idx;
    int          waited;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic [2:0]  op;
    logic        fp;
    logic [4:0]  fl;
    logic        start;
  } mdl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: DATA_W=32, TIMEOUT_CYC=8
  logic        a_rst = 1'b1, a_nxt = 1'b0, a_bck = 1'b0, a_vld = 1'b0;
  logic [15:0] a_sw  = 16'h0;
  logic [31:0] a_res = 32'h0;
  logic [4:0]  a_fl  = 5'h0;
  logic [31:0] a_op_a, a_op_b;
  logic [2:0]  a_opc;
  logic        a_fp, a_start, a_show, a_err;
  logic [15:0] a_led;
  logic [4:0]  a_d3, a_d2, a_d1, a_d0;

  // Instance B: DATA_W=64, TIMEOUT_CYC=0
  logic        b_rst = 1'b1, b_nxt = 1'b0, b_bck = 1'b0, b_vld = 1'b0;
  logic [15:0] b_sw  = 16'h0;
  logic [63:0] b_res = 64'h0;
  logic [4:0]  b_fl  = 5'h0;
  logic [63:0] b_op_a, b_op_b;
  logic [2:0]  b_opc;
  logic        b_fp, b_start, b_show, b_err;
  logic [15:0] b_led;
  logic [4:0]  b_d3, b_d2, b_d1, b_d0;

  alu_entry_ctrl #(.DATA_W(32), .TIMEOUT_CYC(8)) u_a (
    .clk(clk), .rst(a_rst), .next_pulse(a_nxt), .back_pulse(a_bck), .sw(a_sw),
    .alu_op_a(a_op_a), .alu_op_b(a_op_b), .alu_op_code(a_opc), .alu_mode_fp(a_fp),
    .alu_start(a_start), .alu_valid_out(a_vld), .alu_result(a_res), .alu_flags(a_fl),
    .show_result(a_show), .error(a_err), .led(a_led),
    .disp_d3(a_d3), .disp_d2(a_d2), .disp_d1(a_d1), .disp_d0(a_d0)
  );

  alu_entry_ctrl #(.DATA_W(64), .TIMEOUT_CYC(0)) u_b (
    .clk(clk), .rst(b_rst), .next_pulse(b_nxt), .back_pulse(b_bck), .sw(b_sw),
    .alu_op_a(b_op_a), .alu_op_b(b_op_b), .alu_op_code(b_opc), .alu_mode_fp(b_fp),
    .alu_start(b_start), .alu_valid_out(b_vld), .alu_result(b_res), .alu_flags(b_fl),
    .show_result(b_show), .error(b_err), .led(b_led),
    .disp_d3(b_d3), .disp_d2(b_d2), .disp_d1(b_d1), .disp_d0(b_d0)
  );

  mdl_t ma, mb;

  // One clock of the behavioural model: the result of the rules for one edge.
  function automatic mdl_t mstep(mdl_t m, int ch, int tmo, logic r, logic n, logic bk,
                                 logic [15:0] s, logic v, logic [63:0] res, logic [4:0] f);
    mdl_t o;
    o = m;
    o.start = 1'b0;
    if (r) begin
      o.st = S_ID; o.idx = ch - 1; o.waited = 0;
      o.a = '0; o.b = '0; o.res = '0; o.op = '0; o.fp = 1'b0; o.fl = '0;
      return o;
    end
    if (n) bk = 1'b0;
    case (m.st)
      S_ID: if (n) begin o.st = S_LA; o.idx = ch - 1; end
      S_LA, S_LB: begin
        if (n) begin
          if (m.st == S_LA) o.a[16*m.idx +: 16] = s;
          else              o.b[16*m.idx +: 16] = s;
          if (m.idx > 0) o.idx = m.idx - 1;
          else if (m.st == S_LA) begin o.st = S_LB; o.idx = ch - 1; end
          else o.st = S_CF;
        end else if (bk) begin
          if (m.idx < ch - 1) o.idx = m.idx + 1;
          else if (m.st == S_LA) o.st = S_ID;
          else begin o.st = S_LA; o.idx = 0; end
        end
      end
      S_CF: begin
        if (n) begin
          o.op = s[2:0]; o.fp = s[14]; o.st = S_CP; o.start = 1'b1; o.waited = 0;
        end else if (bk) begin
          o.st = S_LB; o.idx = 0;
        end
      end
      S_CP: begin
        if (v) begin
          o.res = res; o.fl = f; o.st = S_DS;
        end else begin
          o.waited = m.waited + 1;
          if (tmo != 0 && o.waited >= tmo) o.st = S_ER;
        end
      end
      S_DS: if (n) o.st = S_ID; else if (bk) o.st = S_CF;
      S_ER: if (n) o.st = S_ID;
      default: o.st = S_ID;
    endcase
    return o;
  endfunction

  function automatic logic [19:0] hex4(logic [15:0] x);
    return {1'b0, x[15:12], 1'b0, x[11:8], 1'b0, x[7:4], 1'b0, x[3:0]};
  endfunction

  function automatic logic [19:0] mdisp(mdl_t m, int ch, logic [15:0] s);
    int p;
    case (m.st)
      S_LA: return {5'h12, 5'h0D, 5'h0A, 5'(m.idx)};
      S_LB: return {5'h12, 5'h0D, 5'h0B, 5'(m.idx)};
      S_CF: return {5'h0C, 5'h00, 5'h10, 5'h0F};
      S_ER: return {5'h0E, 5'h11, 5'h11, 5'h14};
      S_DS: begin
        if (s[13]) return {5'h0F, 5'h12, 4'h0, m.fl[4], 1'b0, m.fl[3:0]};
        p = int'(s[15:14]) % ch;
        return hex4(m.res[16*p +: 16]);
      end
      default: return {5'h14, 5'h14, 5'h14, 5'h14};
    endcase
  endfunction

  function automatic logic [15:0] mled(mdl_t m, int ch, logic [15:0] s);
    int p;
    if (m.st != S_DS) return 16'h0;
    if (s[13]) return {11'b0, m.fl};
    p = int'(s[15:14]) % ch;
    return m.res[16*p +: 16];
  endfunction

  // Model advances on the same edge as the DUTs.
  always @(posedge clk) begin
    ma <= mstep(ma, 2, 8, a_rst, a_nxt, a_bck, a_sw, a_vld, {32'h0, a_res}, a_fl);
    mb <= mstep(mb, 4, 0, b_rst, b_nxt, b_bck, b_sw, b_vld, b_res, b_fl);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cmp_all();
    chk("a_op_a",  64'(a_op_a), ma.a & 64'hFFFF_FFFF);
    chk("a_op_b",  64'(a_op_b), ma.b & 64'hFFFF_FFFF);
    chk("a_opc",   64'(a_opc),  64'(ma.op));
    chk("a_fp",    64'(a_fp),   64'(ma.fp));
    chk("a_start", 64'(a_start), 64'(ma.start));
    chk("a_show",  64'(a_show), 64'(ma.st == S_DS));
    chk("a_err",   64'(a_err),  64'(ma.st == S_ER));
    chk("a_led",   64'(a_led),  64'(mled(ma, 2, a_sw)));
    chk("a_disp",  64'({a_d3, a_d2, a_d1, a_d0}), 64'(mdisp(ma, 2, a_sw)));
    chk("b_op_a",  b_op_a, mb.a);
    chk("b_op_b",  b_op_b, mb.b);
    chk("b_opc",   64'(b_opc),  64'(mb.op));
    chk("b_fp",    64'(b_fp),   64'(mb.fp));
    chk("b_start", 64'(b_start), 64'(mb.start));
    chk("b_show",  64'(b_show), 64'(mb.st == S_DS));
    chk("b_err",   64'(b_err),  64'(mb.st == S_ER));
    chk("b_led",   64'(b_led),  64'(mled(mb, 4, b_sw)));
    chk("b_disp",  64'({b_d3, b_d2, b_d1, b_d0}), 64'(mdisp(mb, 4, b_sw)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  task automatic a_do(input logic n, input logic bk, input logic [15:0] s);
    a_nxt = n; a_bck = bk; a_sw = s;
    tick();
    a_nxt = 1'b0; a_bck = 1'b0;
  endtask

  task automatic b_do(input logic n, input logic bk, input logic [15:0] s);
    b_nxt = n; b_bck = bk; b_sw = s;
    tick();
    b_nxt = 1'b0; b_bck = 1'b0;
  endtask

  initial begin
    int n;
    // Reset both instances
    tick(); tick();
    a_rst = 1'b0; b_rst = 1'b0;
    chk("rst_disp", 64'({a_d3, a_d2, a_d1, a_d0}), 64'(20'hA5294));
    chk("rst_start", 64'(a_start), 64'd0);

    // 32-bit full run
    a_do(1, 0, 16'h0);
    chk("la_disp", 64'({a_d3, a_d2, a_d1, a_d0}), 64'({5'h12, 5'h0D, 5'h0A, 5'h01}));
    a_do(1, 0, 16'h4049);
    a_do(1, 0, 16'h0FDB);
    a_do(1, 0, 16'h4000);
    a_do(1, 0, 16'h0000);
    // Spurious valid while in CONFIG
    a_res = 32'hDEAD_BEEF; a_fl = 5'h1F; a_vld = 1'b1;
    tick();
    a_vld = 1'b0;
    chk("spur_cfg_disp", 64'({a_d3, a_d2, a_d1, a_d0}), 64'({5'h0C, 5'h00, 5'h10, 5'h0F}));
    a_do(1, 0, 16'h4001);
    chk("run_op_a", 64'(a_op_a), 64'h4049_0FDB);
    chk("run_op_b", 64'(a_op_b), 64'h4000_0000);
    chk("run_opc", 64'(a_opc), 64'd1);
    chk("run_fp", 64'(a_fp), 64'd1);
    chk("run_start", 64'(a_start), 64'd1);
    a_res = 32'h4149_0FDB; a_fl = 5'h02; a_vld = 1'b1;
    tick();
    a_vld = 1'b0;
    chk("start_one_cycle", 64'(a_start), 64'd0);
    chk("show_after_valid", 64'(a_show), 64'd1);
    a_sw = 16'h0000; #1;
    chk("page0", 64'({a_d3, a_d2, a_d1, a_d0}), 64'(hex4(16'h0FDB)));
    a_sw = 16'h4000; #1;
    chk("page1", 64'({a_d3, a_d2, a_d1, a_d0}), 64'(hex4(16'h4149)));
    a_sw = 16'h2000; #1;
    chk("flag_led", 64'(a_led), 64'h0002);

    // Re-run from DISPLAY with a new opcode
    a_do(0, 1, 16'h2000);
    a_do(1, 0, 16'h0003);
    chk("rerun_start", 64'(a_start), 64'd1);
    chk("rerun_opc", 64'(a_opc), 64'd3);
    chk("rerun_op_a", 64'(a_op_a), 64'h4049_0FDB);

    // No valid: timeout after 8 cycles
    n = 0;
    while (!a_err && n < 20) begin tick(); n++; end
    chk("timeout_cycles", 64'(n), 64'd8);
    chk("err_disp", 64'({a_d3, a_d2, a_d1, a_d0}), 64'({5'h0E, 5'h11, 5'h11, 5'h14}));
    a_do(0, 1, 16'h0);
    a_do(1, 0, 16'h0);

    // next+back together at LOAD_B idx 0
    a_do(1, 0, 16'h0);
    a_do(1, 0, 16'h1234);
    a_do(1, 0, 16'h5678);
    a_do(1, 0, 16'h9ABC);
    a_do(1, 1, 16'hDEF0);
    chk("both_cfg", 64'({a_d3, a_d2, a_d1, a_d0}), 64'({5'h0C, 5'h00, 5'h10, 5'h0F}));
    // rst mid-COMPUTE, then a late valid
    a_do(1, 0, 16'h0005);
    tick();
    a_rst = 1'b1; tick(); a_rst = 1'b0;
    chk("rst_cp_op_a", 64'(a_op_a), 64'd0);
    chk("rst_cp_start", 64'(a_start), 64'd0);
    a_res = 32'h1111_2222; a_vld = 1'b1; tick(); a_vld = 1'b0;
    chk("late_valid_show", 64'(a_show), 64'd0);

    // 64-bit back-step
    b_do(1, 0, 16'h0);
    b_do(1, 0, 16'hAAAA);
    b_do(0, 1, 16'h0);
    chk("bk_idx3", 64'({b_d3, b_d2, b_d1, b_d0}), 64'({5'h12, 5'h0D, 5'h0A, 5'h03}));
    b_do(0, 1, 16'h0);
    chk("bk_idle", 64'({b_d3, b_d2, b_d1, b_d0}), 64'(20'hA5294));
    b_do(1, 0, 16'h0);
    b_do(1, 0, 16'h1111); b_do(1, 0, 16'h2222); b_do(1, 0, 16'h3333); b_do(1, 0, 16'h4444);
    chk("b_concat", b_op_a, 64'h1111_2222_3333_4444);
    for (int i = 0; i < 4; i++) b_do(1, 0, 16'($urandom));
    b_do(1, 0, 16'h0002);
    for (int i = 0; i < 40; i++) tick();
    chk("no_timeout", 64'(b_err), 64'd0);
    b_res = {$urandom, $urandom}; b_fl = 5'($urandom); b_vld = 1'b1;
    tick();
    b_vld = 1'b0;
    for (int i = 0; i < 8; i++) begin b_sw = 16'(i << 13); tick(); end
    b_do(1, 0, 16'h0);

    // Randomized traffic on both instances
    for (int i = 0; i < 1500; i++) begin
      a_rst = ($urandom_range(0, 63) == 0);
      a_nxt = ($urandom_range(0, 3) == 0);
      a_bck = ($urandom_range(0, 5) == 0);
      a_vld = ($urandom_range(0, 7) == 0);
      a_sw  = 16'($urandom);
      a_res = $urandom;
      a_fl  = 5'($urandom);
      b_rst = ($urandom_range(0, 63) == 0);
      b_nxt = ($urandom_range(0, 3) == 0);
      b_bck = ($urandom_range(0, 5) == 0);
      b_vld = ($urandom_range(0, 9) == 0);
      b_sw  = 16'($urandom);
      b_res = {$urandom, $urandom};
      b_fl  = 5'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
